uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
- Parametrised serial receiver; successor to the fixed 8-bit LED-display receiver on the board link.
- Adds configurable baud divisor, data width, parity, line polarity, mid-bit sampling, start-bit glitch rejection and error flags.
- Delivers each received word through a valid/ready handshake instead of driving LEDs directly.
- Sits between the board input pin and any consumer: LED latch, command decoder or FIFO.

Parameters:
- CLKS_PER_BIT, 10_000_000, clk cycles per bit; must be >= 4. Default gives 10 bit/s at 100 MHz.
- DATA_BITS, 8, data bits per frame, 5..9, LSB first.
- PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
- IDLE_HIGH, 0, 0 = line idles low (start bit = 1, stop bit = 0; existing board link); 1 = standard UART (idle 1, start 0, stop 1).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous active-high reset
- rx_line  in  1  serial input, asynchronous to clk
- rx_dout  out  DATA_BITS  received word, valid while rx_valid = 1
- rx_valid  out  1  holding register full
- rx_ready  in  1  consumer accepts word when rx_valid & rx_ready
- parity_err  out  1  one-cycle pulse, parity mismatch
- frame_err  out  1  one-cycle pulse, bad stop bit
- overrun  out  1  one-cycle pulse, completed word dropped
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous): all outputs 0, FSM in IDLE, counters 0, synchroniser flops loaded with the idle level.
- rx_line passes through a 2-flop synchroniser; all uses below refer to the synchronised value.
- Start level = ~IDLE_HIGH; stop level = IDLE_HIGH.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: the synchronised line at start level on cycle t0 moves FSM to START with the bit counter cleared.
- START: sample at t0 + CLKS_PER_BIT/2 (integer division).
  - Still at start level: go to DATA.
  - Otherwise: false start; return to IDLE with no flags.
- DATA: bit k (k = 0..DATA_BITS-1) sampled at t0 + CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT; stored in shift register position k.
  - After bit DATA_BITS-1: go to PARITY if PARITY_MODE != 0, else to STOP.
- PARITY: sample one bit period later.
  - Odd mode: XOR of data bits and parity bit must be 1.
  - Even mode: the same XOR must be 0.
  - Mismatch is recorded internally and does not abort the frame.
- STOP: sample one bit period later.
  - Not at stop level: frame_err pulses next cycle, word discarded, go to WAIT_IDLE.
  - At stop level with recorded parity mismatch: parity_err pulses next cycle, word discarded, go to IDLE.
  - At stop level and good: word pushed to the holding register next cycle, go to IDLE.
- WAIT_IDLE: stay until the line reads stop/idle level for one cycle, then go to IDLE. This covers break conditions; only one frame_err is produced per break.
- Holding register and handshake:
  - Push sets rx_valid = 1 and rx_dout = word.
  - Pop happens on a cycle with rx_valid & rx_ready; rx_valid clears next cycle unless a push occurs on the same cycle.
  - Push and pop on the same cycle: new word is loaded, rx_valid stays 1, no overrun.
  - Push while full and not popping: old word retained, new word dropped, overrun pulses.
- rx_dout holds its value when rx_valid = 0 (last word, or 0 after reset).
- Bit-period counter: width $clog2(CLKS_PER_BIT); reloads at every sample point, no free-running wrap.
- At most one error pulse per frame.
- Reset mid-frame aborts immediately; no flags are raised and the partial word is lost.

Optional Feature:
- Macro: UART_RX_FIFO_EN.
- Defined:
  - The holding register is replaced by a 4-entry circular FIFO (2-bit pointers, wrap-around; full/empty from a 3-bit count).
  - rx_valid = not empty; rx_dout = head entry (first-word-fall-through).
  - Overrun pulses only when a push arrives with the FIFO full and no simultaneous pop.
- Not defined: single holding register as described in Behaviour.

Test Plan:
- Use CLKS_PER_BIT=16, IDLE_HIGH=0, rx_ready=1, frame 0x5A, no parity -> rx_valid for exactly 1 cycle with rx_dout=0x5A; valid asserts 1 cycle after the stop sample plus synchroniser latency; no error flags.
- Apply a 4-cycle start-level glitch -> FSM returns to IDLE, busy drops, no rx_valid, no flags.
- Set PARITY_MODE=2 and send 0x07 with parity bit 0 -> parity_err pulses once, no rx_valid. Resend with parity bit 1 -> rx_dout=0x07.
- Send 0x3C with the stop bit at the wrong level, then hold the line at start level for 40 bit times -> a single frame_err pulse, busy held high through WAIT_IDLE, next frame 0x81 received correctly.
- Hold rx_ready=0 and send 0x11 then 0x22 -> rx_dout stays 0x11 and overrun pulses once. With UART_RX_FIFO_EN, 5 words are needed to trigger overrun; the pops then return them in order.
- Assert rst during DATA of 0xF0 -> all outputs 0 asynchronously; after release, frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// Receive-side bus for uart_rx_param: word handshake, error pulses, busy and FSM state.
// The receiver drives through the master modport; the consumer uses the slave modport.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  // Handshake: a word transfers on every clk edge where rx_valid and rx_ready are both 1.
  // rx_valid never drops while a word is pending, and rx_dout is stable until it is taken.
  logic [DATA_BITS-1:0] rx_dout;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;
  logic [2:0]           dbg_state;

  modport master (
    output rx_dout, rx_valid, parity_err, frame_err, overrun, busy, dbg_state,
    input  rx_ready
  );

  modport slave (
    input  rx_dout, rx_valid, parity_err, frame_err, overrun, busy, dbg_state,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised serial receiver: mid-bit sampling, glitch-rejecting start detect, parity/frame/overrun flags.
// Define UART_RX_FIFO_EN to replace the single holding register with a 4-entry FIFO.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 10_000_000,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int IDLE_HIGH    = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx_line,
  uart_rx_param_if.master bus
);

  localparam int   CW        = $clog2(CLKS_PER_BIT);
  localparam int   BW        = $clog2(DATA_BITS);
  localparam logic STOP_LVL  = (IDLE_HIGH != 0);
  localparam logic START_LVL = ~STOP_LVL;
  localparam logic PAR_WANT  = (PARITY_MODE == 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t               state;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 busy_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 ovr_q;
  logic                 tick;
  logic                 push;
  logic                 pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {2{STOP_LVL}};
    else     sync_q <= {sync_q[0], rx_line};
  end
  assign rx_s = sync_q[1];

  // The first sample lands half a bit after the edge; later ones a whole bit apart.
  assign tick = (cnt == ((state == START) ? HALF_M1 : FULL_M1));
  assign push = (state == STOP) && tick && (rx_s == STOP_LVL) && !par_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      if (state == IDLE || state == WAIT_IDLE || tick) cnt <= '0;
      else                                            cnt <= cnt + CW'(1);
      case (state)
        IDLE: begin
          if (rx_s == START_LVL) begin
            state   <= START;
            busy_q  <= 1'b1;
            bit_idx <= '0;
            par_bad <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            if (rx_s == START_LVL) begin
              state <= DATA;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shreg[bit_idx] <= rx_s;
            if (bit_idx == LAST_BIT) state <= (PARITY_MODE != 0) ? PARITY : STOP;
            else                     bit_idx <= bit_idx + BW'(1);
          end
        end
        PARITY: begin
          if (tick) begin
            par_bad <= ((^shreg) ^ rx_s) != PAR_WANT;
            state   <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (rx_s != STOP_LVL) begin
              ferr_q <= 1'b1;
              state  <= WAIT_IDLE;
            end else begin
              perr_q <= par_bad;
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        WAIT_IDLE: begin
          // A held break yields one frame error; re-arm only once the line goes idle.
          if (rx_s == STOP_LVL) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  logic [DATA_BITS-1:0] mem [4];
  logic [1:0]           wr_ptr;
  logic [1:0]           rd_ptr;
  logic [2:0]           count;
  logic                 full;
  logic                 do_wr;

  assign full  = (count == 3'd4);
  assign pop   = (count != 3'd0) && bus.rx_ready;
  assign do_wr = push && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      ovr_q <= push && full && !pop;
      if (do_wr) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, do_wr} - {2'b00, pop};
    end
  end

  assign bus.rx_valid = (count != 3'd0);
  assign bus.rx_dout  = mem[rd_ptr];
`else
  logic [DATA_BITS-1:0] dout_q;
  logic                 valid_q;

  assign pop = valid_q && bus.rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (push) begin
        // A full register that is not being drained keeps its word; the new one is lost.
        if (!valid_q || pop) begin
          dout_q  <= shreg;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (pop) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.rx_valid = valid_q;
  assign bus.rx_dout  = dout_q;
`endif

  assign bus.busy       = busy_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.dbg_state  = state;

endmodule
